// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1001 Mealy detector: WIDTH-bit words in over valid/ready,
// one bit per cycle out on sout, with a holding register so consecutive words stream gap-free.
module seq_bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned   CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             accept;
   logic             free;
   logic             load;
   logic [WIDTH-1:0] next_word;
   logic             next_first;

   assign din_ready = !hold_full && !reset;
   assign accept    = din_valid && din_ready;
   assign free      = (state == S_IDLE) || (cnt == LAST);
   assign busy      = (state == S_SHIFT) || hold_full;

   // A held word always wins the reload slot; ready is low then, so no new word competes.
   always_comb begin
      load       = free && (hold_full || accept);
      next_word  = hold_full ? hold : din;
      next_first = MSB_FIRST ? next_word[WIDTH-1] : next_word[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         shreg      <= '0;
         hold       <= '0;
         hold_full  <= 1'b0;
         sout       <= IDLE_BIT;
         sout_valid <= 1'b0;
         word_done  <= 1'b0;
      end else begin
         // shreg keeps the bit currently on sout at its output end; the next bit sits beside it
         if (load) begin
            state      <= S_SHIFT;
            cnt        <= '0;
            shreg      <= next_word;
            sout       <= next_first;
            sout_valid <= 1'b1;
            word_done  <= 1'b0;
         end else if (!free) begin
            cnt        <= cnt + 1'b1;
            shreg      <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            sout       <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
            sout_valid <= 1'b1;
            word_done  <= (cnt == PENULT);
         end else begin
            state      <= S_IDLE;
            cnt        <= '0;
            sout       <= IDLE_BIT;
            sout_valid <= 1'b0;
            word_done  <= 1'b0;
         end

         if (free && hold_full) begin
            hold_full <= 1'b0;
         end else if (accept && !free) begin
            hold      <= din;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: default MSB-first instance, an LSB-first instance,
// and an IDLE_BIT=1 instance, each checked cycle by cycle against hand-computed bit streams.
module tb_seq_bit_serializer;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic [7:0] din_a = '0, din_b = '0, din_c = '0;
   logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
   logic       ready_a, ready_b, ready_c;
   logic       sout_a, sout_b, sout_c;
   logic       sv_a, sv_b, sv_c;
   logic       done_a, done_b, done_c;
   logic       busy_a, busy_b, busy_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
      .clk(clk), .reset(reset), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
      .sout(sout_a), .sout_valid(sv_a), .word_done(done_a), .busy(busy_a));

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
      .clk(clk), .reset(reset), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
      .sout(sout_b), .sout_valid(sv_b), .word_done(done_b), .busy(busy_b));

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_c (
      .clk(clk), .reset(reset), .din(din_c), .din_valid(valid_c), .din_ready(ready_c),
      .sout(sout_c), .sout_valid(sv_c), .word_done(done_c), .busy(busy_c));

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (sout_a !== 1'b0) begin errors++; $display("FAIL reset_sout got %b expected 0", sout_a); end
      checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL reset_sout_valid got %b expected 0", sv_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_word_done got %b expected 0", done_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_a); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_during got %b expected 0", ready_a); end
      checks++; if (sout_c !== 1'b1) begin errors++; $display("FAIL reset_idle1_sout got %b expected 1", sout_c); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b expected 1", ready_a); end
      checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_after_b got %b expected 1", ready_b); end
      checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL reset_valid_after got %b expected 0", sv_a); end
   endtask

   task automatic test_single_word();
      logic [7:0] exp_w = 8'b1001_0000;
      logic [3:0] hist = '0;
      logic       e_bit, e_done, det;
      din_a = 8'h90; valid_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) valid_a = 1'b0;
         e_bit  = exp_w[7-i];
         e_done = (i == 7);
         checks++; if (sout_a !== e_bit) begin errors++; $display("FAIL single_bit[%0d] got %b expected %b", i, sout_a, e_bit); end
         checks++; if (sv_a !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b expected 1", i, sv_a); end
         checks++; if (done_a !== e_done) begin errors++; $display("FAIL single_done[%0d] got %b expected %b", i, done_a, e_done); end
         hist = {hist[2:0], sout_a};
         det  = (hist == 4'b1001);
         checks++; if (det !== (i == 3)) begin errors++; $display("FAIL single_detect[%0d] got %b expected %b", i, det, (i == 3)); end
      end
      @(negedge clk);
      checks++; if (sout_a !== 1'b0) begin errors++; $display("FAIL single_idle_sout got %b expected 0", sout_a); end
      checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b expected 0", sv_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b expected 0", busy_a); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream = 16'hA53C;
      logic        e_bit, e_done, e_ready;
      din_a = 8'hA5; valid_a = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0) din_a = 8'h3C;
         if (i == 1) valid_a = 1'b0;
         e_bit   = stream[15-i];
         e_done  = (i == 7) || (i == 15);
         e_ready = !(i >= 1 && i <= 7);
         checks++; if (sout_a !== e_bit) begin errors++; $display("FAIL b2b_bit[%0d] got %b expected %b", i, sout_a, e_bit); end
         checks++; if (sv_a !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b expected 1", i, sv_a); end
         checks++; if (done_a !== e_done) begin errors++; $display("FAIL b2b_done[%0d] got %b expected %b", i, done_a, e_done); end
         checks++; if (ready_a !== e_ready) begin errors++; $display("FAIL b2b_ready[%0d] got %b expected %b", i, ready_a, e_ready); end
      end
      @(negedge clk);
      checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %b expected 0", sv_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b expected 0", busy_a); end
   endtask

   task automatic test_backpressure();
      logic [23:0] stream = 24'h010203;
      logic [7:0]  words [3] = '{8'h01, 8'h02, 8'h03};
      logic        e_bit, e_done, e_ready, acc;
      int          widx = 0;
      din_a = words[0]; valid_a = 1'b1;
      acc = valid_a && ready_a;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (acc) begin
            widx++;
            if (widx < 3) din_a = words[widx];
            else valid_a = 1'b0;
         end
         e_bit   = stream[23-i];
         e_done  = (i % 8 == 7);
         e_ready = !((i >= 1 && i <= 7) || (i >= 9 && i <= 15));
         checks++; if (sout_a !== e_bit) begin errors++; $display("FAIL bp_bit[%0d] got %b expected %b", i, sout_a, e_bit); end
         checks++; if (sv_a !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b expected 1", i, sv_a); end
         checks++; if (done_a !== e_done) begin errors++; $display("FAIL bp_done[%0d] got %b expected %b", i, done_a, e_done); end
         checks++; if (ready_a !== e_ready) begin errors++; $display("FAIL bp_ready[%0d] got %b expected %b", i, ready_a, e_ready); end
         acc = valid_a && ready_a;
      end
      @(negedge clk);
      checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b expected 0", sv_a); end
      checks++; if (widx !== 3) begin errors++; $display("FAIL bp_accept_count got %0d expected 3", widx); end
   endtask

   task automatic test_lsb_first();
      logic [7:0] exp_w = 8'b1001_0000;
      logic       e_bit, e_done;
      din_b = 8'h09; valid_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) valid_b = 1'b0;
         e_bit  = exp_w[7-i];
         e_done = (i == 7);
         checks++; if (sout_b !== e_bit) begin errors++; $display("FAIL lsb_bit[%0d] got %b expected %b", i, sout_b, e_bit); end
         checks++; if (sv_b !== 1'b1) begin errors++; $display("FAIL lsb_valid[%0d] got %b expected 1", i, sv_b); end
         checks++; if (done_b !== e_done) begin errors++; $display("FAIL lsb_done[%0d] got %b expected %b", i, done_b, e_done); end
      end
      @(negedge clk);
      checks++; if (sv_b !== 1'b0) begin errors++; $display("FAIL lsb_idle_valid got %b expected 0", sv_b); end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] exp_w = 8'h81;
      logic       e_bit, e_done;
      din_a = 8'hFF; valid_a = 1'b1;
      @(negedge clk);
      checks++; if (sout_a !== 1'b1 || sv_a !== 1'b1) begin errors++; $display("FAIL rst_mid_bit0 got %b/%b expected 1/1", sout_a, sv_a); end
      din_a = 8'h00;
      @(negedge clk);
      checks++; if (busy_a !== 1'b1 || ready_a !== 1'b0) begin errors++; $display("FAIL rst_mid_holdfull busy/ready got %b/%b expected 1/0", busy_a, ready_a); end
      valid_a = 1'b0;
      @(negedge clk);
      checks++; if (sout_a !== 1'b1) begin errors++; $display("FAIL rst_mid_bit2 got %b expected 1", sout_a); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (sout_a !== 1'b0) begin errors++; $display("FAIL rst_mid_sout got %b expected 0", sout_a); end
      checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b expected 0", sv_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", busy_a); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b expected 0", ready_a); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (sv_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_after valid/busy got %b/%b expected 0/0", sv_a, busy_a); end
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rst_mid_after_ready got %b expected 1", ready_a); end
      din_a = 8'h81; valid_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) valid_a = 1'b0;
         e_bit  = exp_w[7-i];
         e_done = (i == 7);
         checks++; if (sout_a !== e_bit || sv_a !== 1'b1) begin errors++; $display("FAIL rst_new_bit[%0d] got %b/%b expected %b/1", i, sout_a, sv_a, e_bit); end
         checks++; if (done_a !== e_done) begin errors++; $display("FAIL rst_new_done[%0d] got %b expected %b", i, done_a, e_done); end
      end
      @(negedge clk);
      checks++; if (sv_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_new_idle valid/busy got %b/%b expected 0/0", sv_a, busy_a); end
   endtask

   task automatic test_idle_level();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (sout_c !== 1'b1 || sv_c !== 1'b0) begin errors++; $display("FAIL idle1_pre[%0d] got %b/%b expected 1/0", i, sout_c, sv_c); end
      end
      din_c = 8'h00; valid_c = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) valid_c = 1'b0;
         checks++; if (sout_c !== 1'b0 || sv_c !== 1'b1) begin errors++; $display("FAIL idle1_word[%0d] got %b/%b expected 0/1", i, sout_c, sv_c); end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (sout_c !== 1'b1 || sv_c !== 1'b0) begin errors++; $display("FAIL idle1_post[%0d] got %b/%b expected 1/0", i, sout_c, sv_c); end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_lsb_first();
      test_reset_mid_word();
      test_idle_level();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial feeder directly upstream of the 1001 Mealy sequence detector (mealy1).
- Accepts WIDTH-bit words over a valid/ready handshake and emits them as one bit per clk cycle on sout, which drives the detector's ip.
- Sequential elements: one holding register plus a shift register. Consecutive words stream with no idle bit between them.
- Drives a defined idle level whenever no word is being shifted, because the detector has no valid input.

Parameters:
- WIDTH, 8, word length in bits; legal values are WIDTH >= 2.
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
- IDLE_BIT, 0, value driven on sout while sout_valid = 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only when din_valid && din_ready.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit to the detector ip.
- sout_valid  output  1  sout carries a word bit.
- word_done  output  1  one-cycle pulse coincident with the final bit of each word.
- busy  output  1  shift register or holding register occupied.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising clk edge.
- Reset values, in effect after the edge where reset = 1:
  - sout = IDLE_BIT, sout_valid = 0, word_done = 0, busy = 0.
  - Holding register empty, shift register empty, bit counter = 0.
  - din_ready = 0 while reset is high; din_ready = 1 in the first cycle after reset is released.
- Output timing: sout, sout_valid and word_done are registered. din_ready = !hold_full, decoded combinationally from registers.
- Shifter states: IDLE (shift register empty) and SHIFT (counter 0..WIDTH-1).
- "Shifter free at edge k" means the shifter is in IDLE, or is in SHIFT with counter = WIDTH-1.
- Accept at edge k (din_valid && din_ready):
  - If the shifter is free, din loads straight into the shift register.
  - Bit 0 of the output order appears on sout in the cycle after edge k; sout_valid = 1 for exactly WIDTH cycles.
  - Otherwise din loads into the holding register, and din_ready drops in the next cycle.
- Output order:
  - MSB_FIRST = 1: din[WIDTH-1] first, down to din[0].
  - MSB_FIRST = 0: din[0] first, up to din[WIDTH-1].
- Last-bit edge (counter = WIDTH-1), resolved in this priority order:
  1. Hold full: the shifter loads the hold word, the hold empties, and din_ready = 1 next cycle. Any word offered that cycle was not accepted (ready was 0) and stays pending.
  2. Hold empty and a word accepted that same edge: the word loads directly into the shifter.
  3. Otherwise: the shifter goes to IDLE, and next cycle sout = IDLE_BIT, sout_valid = 0.
- Cases 1 and 2 produce zero gap: the next word's first bit immediately follows the last bit.
- word_done = 1 exactly in cycles where sout_valid = 1 and the final bit of a word is on sout.
- busy = shift register occupied OR hold full.
- Counter width is clog2(WIDTH); it wraps to 0 on every reload.
- Reset mid-word or with the hold full:
  - Both registers are discarded and no partial bits are emitted afterwards.
  - The next cycle shows the reset values.
- din and din_valid are ignored while din_ready = 0. Upstream holds din stable until accepted.

Test Plan:
1. Reset 2 cycles, then din=8'b1001_0000 with a single-cycle din_valid, MSB_FIRST=1 -> sout = 1,0,0,1,0,0,0,0 over the next 8 cycles with sout_valid=1; word_done only on the 8th bit; then sout=0, sout_valid=0, busy=0. The downstream mealy1 op pulses once, on the 4th bit.
2. Back-to-back: 8'hA5 then 8'h3C, din_valid held -> 16 contiguous valid bits 1010_0101_0011_1100 with no gap; word_done on bits 8 and 16; din_ready low from the cycle after the 2nd accept until the first word's last-bit edge.
3. Backpressure: three words 8'h01, 8'h02, 8'h03 offered continuously -> the third waits with din_ready=0 until the hold empties; 24 contiguous bits in order; no word lost or duplicated.
4. Instance with MSB_FIRST=0, din=8'h09 -> sout = 1,0,0,1,0,0,0,0.
5. Reset asserted after the 3rd bit of 8'hFF with the hold full (8'h00) -> next cycle sout=IDLE_BIT, sout_valid=0, busy=0; after release, a new word 8'h81 emits from its first bit (1,0,0,0,0,0,0,1) with no remnants.
6. Instance with IDLE_BIT=1 and no input -> sout=1, sout_valid=0 continuously after reset; on accepting 8'h00, sout=0 for exactly 8 cycles, then back to 1.
